data_memory_block: RTL and testbench

//  Block-organised data memory directly downstream of the data-cache FSM. Services one

---
 rtl/data_memory_block_pkg.sv | 19 +
 rtl/data_memory_block_if.sv | 26 ++
 rtl/data_memory_block.sv | 109 ++++++++++
 tb/tb_data_memory_block.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_block_pkg.sv
// Shared definitions for the block data memory and the data cache that drives it.
package data_memory_block_pkg;

  localparam int DMB_ADDR_W  = 6;
  localparam int DMB_BLOCK_W = 32;
  localparam int DMB_LATENCY = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } dmb_state_e;

  // Counter must hold LATENCY-1 and reach zero without wrapping.
  function automatic int dmb_cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/data_memory_block_if.sv
// Cache <-> memory block-transfer bus; master is the cache FSM, slave is the memory.
interface data_memory_block_if
  import data_memory_block_pkg::*;
#(
  parameter int ADDR_W  = DMB_ADDR_W,
  parameter int BLOCK_W = DMB_BLOCK_W
) ();

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/data_memory_block.sv
// Block-organised data memory: one whole-block read or write per request after a
// fixed LATENCY, with busywait stalling the cache until the transfer completes.
module data_memory_block
  import data_memory_block_pkg::*;
#(
  parameter int ADDR_W  = DMB_ADDR_W,
  parameter int BLOCK_W = DMB_BLOCK_W,
  parameter int LATENCY = DMB_LATENCY
) (
  input  logic                clock,
  input  logic                reset,
  data_memory_block_if.slave  mem
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = dmb_cnt_w(LATENCY);

  dmb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic               is_wr_q, is_wr_d;
  logic [BLOCK_W-1:0] rdata_q, rdata_d;
  logic [BLOCK_W-1:0] array_q [DEPTH];
  logic               array_we_s;
  logic               busy_s;

  // Next-state, counter, commit and busywait decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    rdata_d    = rdata_q;
    array_we_s = 1'b0;
    busy_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem.mem_read || mem.mem_write) begin
          // Busywait rises with the request so the cache never sees a false ready.
          busy_s  = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          addr_d  = mem.mem_address;
          wdata_d = mem.mem_writedata;
          is_wr_d = mem.mem_write;
        end else begin
          busy_s  = 1'b0;
        end
      end
      ST_BUSY: begin
        busy_s = 1'b1;
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_DONE;
          if (is_wr_q) begin
            array_we_s = 1'b1;
          end else begin
            rdata_d = array_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control, latched request and readdata registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {BLOCK_W{1'b0}};
      is_wr_q <= 1'b0;
      rdata_q <= {BLOCK_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Block storage, cleared entirely by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        array_q[i] <= {BLOCK_W{1'b0}};
      end
    end else if (array_we_s) begin
      array_q[addr_q] <= wdata_q;
    end else begin
      array_q[addr_q] <= array_q[addr_q];
    end
  end

  assign mem.mem_busywait = busy_s;
  assign mem.mem_readdata = rdata_q;

endmodule

// File: tb/tb_data_memory_block.sv
// Self-checking bench: directed table, cache-style sequences and randomized ops vs a model.
module tb_data_memory_block;

  localparam int LAT = 5;

  logic clock;
  logic reset;

  data_memory_block_if bus ();
  data_memory_block_if bus1 ();

  data_memory_block dut (
    .clock (clock),
    .reset (reset),
    .mem   (bus)
  );

  data_memory_block #(.LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .mem   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [64];
  logic [31:0] last_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    last_rd = 32'h0;
  endtask

  // One cache-style access. Called past a posedge, either in IDLE (from_done=0) or in the
  // DONE cycle of the previous op (from_done=1). Returns in this op's DONE cycle (or IDLE if drop).
  task automatic op(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                    input logic [31:0] exp_rd, input bit from_done, input bit drop, input bit scramble);
    int n;
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.mem_address   = a;
    bus.mem_writedata = d;
    if (from_done) begin
      @(posedge clock); #1;
    end else begin
      #1;
    end
    check("busy_at_request", {31'h0, bus.mem_busywait}, 32'h1);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
      if (bus.mem_busywait && scramble) begin
        bus.mem_read      = 1'($urandom);
        bus.mem_write     = 1'($urandom);
        bus.mem_address   = 6'($urandom);
        bus.mem_writedata = $urandom;
      end
    end while (bus.mem_busywait && n < 300);
    check("latency_edges", n, LAT + 1);
    check("readdata", bus.mem_readdata, exp_rd);
    if (drop) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      @(posedge clock); #1;
      check("idle_busy_low", {31'h0, bus.mem_busywait}, 32'h0);
    end
  endtask

  // Model-driven access: computes expected readdata from the spec rules.
  task automatic mop(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                     input bit from_done, input bit drop, input bit scramble);
    logic [31:0] e;
    if (wr) begin
      e = last_rd;
    end else begin
      e = model[a];
      last_rd = e;
    end
    op(rd, wr, a, d, e, from_done, drop, scramble);
    if (wr) model[a] = d;
  endtask

  initial begin
    int n;
    bit prev_drop;
    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
    bus.mem_address = 6'h0; bus.mem_writedata = 32'h0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
    bus1.mem_address = 6'h0; bus1.mem_writedata = 32'h0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("rst_busy", {31'h0, bus.mem_busywait}, 32'h0);
    check("rst_rdata", bus.mem_readdata, 32'h0);

    // Test 1: write in flight, reset mid-stream, then read 6'h05 returns zero.
    @(posedge clock); #1;
    bus.mem_write = 1'b1; bus.mem_address = 6'h05; bus.mem_writedata = 32'hFFFFFFFF;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    bus.mem_write = 1'b0;
    #1 check("rst_mid_busy", {31'h0, bus.mem_busywait}, 32'h0);
    @(posedge clock); #1 reset = 1'b1;
    model_reset();
    @(posedge clock); #1;

    vt[0] = '{1'b1, 1'b0, 6'h05, 32'h0,        32'h00000000};
    vt[1] = '{1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h00000000};
    vt[2] = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
    vt[3] = '{1'b0, 1'b1, 6'h31, 32'hCAFEF00D, 32'hDEADBEEF};
    vt[4] = '{1'b1, 1'b1, 6'h07, 32'hA5A5A5A5, 32'hDEADBEEF};
    vt[5] = '{1'b1, 1'b0, 6'h07, 32'h0,        32'hA5A5A5A5};
    vt[6] = '{1'b1, 1'b0, 6'h31, 32'h0,        32'hCAFEF00D};
    vt[7] = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h00000000};
    for (int i = 0; i < 8; i++) begin
      op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, 1'b0, 1'b1, 1'b0);
      if (vt[i].wr) model[vt[i].addr] = vt[i].wdata;
      else last_rd = vt[i].exp_rdata;
    end

    // Test 3: write-back immediately followed by refill, no bubble.
    mop(1'b0, 1'b1, 6'h11, 32'h12345678, 1'b0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 6'h31, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
    last_rd = 32'hCAFEF00D;
    op(1'b1, 1'b0, 6'h11, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0);
    last_rd = 32'h12345678;

    // Test 5: address (and op) changed during BUSY; the latched read of 6'h01 completes.
    mop(1'b0, 1'b1, 6'h01, 32'h11111111, 1'b0, 1'b1, 1'b0);
    mop(1'b0, 1'b1, 6'h02, 32'h22222222, 1'b0, 1'b1, 1'b0);
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_address = 6'h01;
    @(posedge clock); #1;
    bus.mem_address = 6'h02; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
    bus.mem_writedata = 32'hFFFF0000;
    n = 1;
    while (bus.mem_busywait && n < 300) begin
      @(posedge clock); #1; n++;
    end
    check("mid_change_latency", n, LAT + 1);
    check("mid_change_rdata", bus.mem_readdata, 32'h11111111);
    bus.mem_write = 1'b0;
    @(posedge clock); #1;
    last_rd = 32'h11111111;
    mop(1'b1, 1'b0, 6'h02, 32'h0, 1'b0, 1'b1, 1'b0);

    // Test 6: reset at BUSY counter==1 of a write aborts it.
    bus.mem_write = 1'b1; bus.mem_address = 6'h2A; bus.mem_writedata = 32'h0BADF00D;
    @(posedge clock);
    repeat (LAT - 2) @(posedge clock);
    #1 reset = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    check("rst_cnt1_busy", {31'h0, bus.mem_busywait}, 32'h0);
    check("rst_cnt1_rdata", bus.mem_readdata, 32'h0);
    @(posedge clock); #1 reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    mop(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, 1'b1, 1'b0);

    // Randomized ops with mid-op scrambling and back-to-back chaining.
    prev_drop = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int kind;
      logic [5:0] a;
      bit dr;
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      dr = (i == 149) ? 1'b1 : 1'($urandom);
      mop(kind != 1, kind != 0, a, $urandom, !prev_drop, dr, 1'($urandom));
      prev_drop = dr;
    end

    // LATENCY=1 instance: write then back-to-back read.
    bus1.mem_write = 1'b1; bus1.mem_address = 6'h0A; bus1.mem_writedata = 32'h13579BDF;
    #1 check("l1_req_busy", {31'h0, bus1.mem_busywait}, 32'h1);
    @(posedge clock); #1 check("l1_busy", {31'h0, bus1.mem_busywait}, 32'h1);
    @(posedge clock); #1 check("l1_done", {31'h0, bus1.mem_busywait}, 32'h0);
    check("l1_rdata_held", bus1.mem_readdata, 32'h0);
    bus1.mem_write = 1'b0; bus1.mem_read = 1'b1;
    @(posedge clock); #1 check("l1_rd_req_busy", {31'h0, bus1.mem_busywait}, 32'h1);
    @(posedge clock); #1 check("l1_rd_busy", {31'h0, bus1.mem_busywait}, 32'h1);
    @(posedge clock); #1 check("l1_rd_done", {31'h0, bus1.mem_busywait}, 32'h0);
    check("l1_rdata", bus1.mem_readdata, 32'h13579BDF);
    bus1.mem_read = 1'b0;
    @(posedge clock); #1 check("l1_idle", {31'h0, bus1.mem_busywait}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
